// File: rtl/shared_timer_arbiter_pkg.sv
// Shared state encoding and default sizing for the shared countdown timer.
// Imported by the arbiter top and its prescaler.
package shared_timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIV   = 10000;
    localparam int DEF_DUR_W = 8;

endpackage

// File: rtl/shared_timer_arbiter_tick_prescaler.sv
// Divides clk into a 1-cycle tick every DIV enabled cycles; tick is combinational off the count.
// No backpressure: counts whenever en is high, clr forces the count back to 0.
module tick_prescaler
    import shared_timer_arbiter_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] presc;

    // rst_n is active-high in this block
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = en && (presc == LAST);

endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin owner of one shared countdown timer; grant 1 cycle after req, done after D*DIV RUN cycles.
// Requesters hold req until granted; others wait until the timer returns to IDLE.
module shared_timer_arbiter
    import shared_timer_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DIV   = DEF_DIV,
    parameter int DUR_W = DEF_DUR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DUR_W-1:0] req_dur,
    input  logic [NREQ-1:0]       cancel,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [DUR_W-1:0]      remain,
    output logic                  tick,
    output logic [NREQ-1:0]       done_pulse
);

    localparam int            PW       = $clog2(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_d;
    logic [DUR_W-1:0]  remain_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_q, rr_d, rr_nxt;
    logic [PW-1:0]     cand, pick_idx;
    logic              pick_vld;
    logic              presc_en, presc_clr;
    logic [DUR_W-1:0]  dur_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_dur
        assign dur_arr[i] = req_dur[i*DUR_W +: DUR_W];
    end

    assign rr_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // Scan from the highest offset down so the requester nearest rr_q wins.
    always_comb begin
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_q) + k) % NREQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        remain_d = remain;
        owner_d  = owner_q;
        rr_d     = rr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d  = pick_idx;
                    grant_d  = NREQ'(1) << pick_idx;
                    remain_d = dur_arr[pick_idx];
                    state_d  = (dur_arr[pick_idx] == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // An owner abort takes priority over a tick landing on the same cycle.
                if (cancel[owner_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    remain_d = '0;
                    rr_d     = rr_nxt;
                end else if (tick) begin
                    remain_d = (remain != '0) ? remain - 1'b1 : '0;
                    if (remain == DUR_W'(1)) begin
                        state_d = DONE;
                        grant_d = '0;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                remain_d = '0;
                rr_d     = rr_nxt;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            grant   <= '0;
            remain  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            remain  <= remain_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // Clearing on the last RUN cycle keeps presc at 0 everywhere outside RUN.
    assign presc_en  = (state_q == RUN);
    assign presc_clr = (state_d != RUN);

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    assign busy       = (state_q != IDLE);
    assign done_pulse = (state_q == DONE) ? (NREQ'(1) << owner_q) : '0;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter with DIV=4, NREQ=2, DUR_W=8: vector table, scoreboard on done_pulse,
// and hand sequences for round-robin alternation, cancel and mid-run reset.
module tb_shared_timer_arbiter;

    localparam int NREQ  = 2;
    localparam int DIV   = 4;
    localparam int DUR_W = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [1:0]  req     = '0;
    logic [1:0]  cancel  = '0;
    logic [15:0] req_dur = '0;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  remain;
    logic        tick;
    logic [1:0]  done_pulse;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0] mask;
        int         cyc;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;

    typedef struct {
        int         who;
        int         dur;
        logic [1:0] exp_grant;
        int         exp_ticks;
    } vec_t;
    vec_t vt[5];

    shared_timer_arbiter #(
        .NREQ  (NREQ),
        .DIV   (DIV),
        .DUR_W (DUR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_dur    (req_dur),
        .cancel     (cancel),
        .grant      (grant),
        .busy       (busy),
        .remain     (remain),
        .tick       (tick),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp_v, cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  int'(grant),      0);
        chk({tag, "_busy"},   int'(busy),       0);
        chk({tag, "_remain"}, int'(remain),     0);
        chk({tag, "_tick"},   int'(tick),       0);
        chk({tag, "_done"},   int'(done_pulse), 0);
    endtask

    task automatic sb_push(input logic [1:0] mask, input int at_cyc);
        sb_t e;
        e.mask = mask;
        e.cyc  = at_cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    // Scoreboard: every done_pulse must match the next expected owner and cycle.
    always @(negedge clk) begin
        if (done_pulse != 2'b00) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", int'(done_pulse), 0);
            end else begin
                sb_e = sbq.pop_front();
                chk("sb_done_mask",  int'(done_pulse), int'(sb_e.mask));
                chk("sb_done_cycle", cyc,              sb_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int c, ticks, n;
        logic seen;

        vt[0] = '{who: 0, dur: 2, exp_grant: 2'b01, exp_ticks: 2};
        vt[1] = '{who: 1, dur: 3, exp_grant: 2'b10, exp_ticks: 3};
        vt[2] = '{who: 0, dur: 0, exp_grant: 2'b01, exp_ticks: 0};
        vt[3] = '{who: 1, dur: 1, exp_grant: 2'b10, exp_ticks: 1};
        vt[4] = '{who: 1, dur: 0, exp_grant: 2'b10, exp_ticks: 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b0;

        // req0, dur 3: grant at t+1, tick every 4th cycle, remain 3,2,1, done at t+13
        @(negedge clk);
        c = cyc;
        req = 2'b01;
        req_dur = {8'd0, 8'd3};
        sb_push(2'b01, c + 1 + 3 * DIV);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 1) req = 2'b00;
            chk("d3_grant",  int'(grant),  (j <= 12) ? 1 : 0);
            chk("d3_tick",   int'(tick),   (j <= 12 && j % 4 == 0) ? 1 : 0);
            chk("d3_remain", int'(remain), (j <= 12) ? 3 - (j - 1) / 4 : 0);
            chk("d3_busy",   int'(busy),   (j <= 13) ? 1 : 0);
        end

        // Single-requester vectors
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            @(negedge clk);
            req = 2'(1 << vt[v].who);
            req_dur = {8'(vt[v].dur), 8'(vt[v].dur)};
            sb_push(req, cyc + 1 + vt[v].dur * DIV);
            @(negedge clk);
            chk("vec_grant", int'(grant), int'(vt[v].exp_grant));
            req = 2'b00;
            ticks = int'(tick);
            seen = (done_pulse != 2'b00);
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                ticks += int'(tick);
                seen = (done_pulse != 2'b00);
            end
            chk("vec_done_seen", int'(seen), 1);
            chk("vec_ticks", ticks, vt[v].exp_ticks);
            if (vt[v].dur == 0) begin
                @(negedge clk);
                chk("vec_d0_grant_drop", int'(grant), 0);
            end
        end

        // Alternation from rr_ptr=0 with both requesters held
        wait_idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        c = cyc;
        req = 2'b11;
        req_dur = {8'd1, 8'd1};
        sb_push(2'b01, c + 5);
        sb_push(2'b10, c + 11);
        sb_push(2'b01, c + 17);
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= 4)        chk("alt_grant", int'(grant), 1);
            else if (j >= 7 && j <= 10)  chk("alt_grant", int'(grant), 2);
            else if (j >= 13 && j <= 16) chk("alt_grant", int'(grant), 1);
            else                         chk("alt_grant", int'(grant), 0);
            if (j == 6) chk("alt_idle_gap", int'(busy), 0);
        end
        req = 2'b00;

        // Owner cancel on the cycle tick=1 and remain=1
        wait_idle();
        @(negedge clk);
        req = 2'b01;
        req_dur = {8'd0, 8'd5};
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            req = 2'b00;
            seen = tick && (remain == 8'd1);
        end
        chk("cancel_at_cycle", n, 20);
        cancel = 2'b01;
        @(negedge clk);
        cancel = 2'b00;
        chk("cancel_grant",  int'(grant),  0);
        chk("cancel_busy",   int'(busy),   0);
        chk("cancel_remain", int'(remain), 0);
        chk("cancel_done",   int'(done_pulse), 0);

        // Non-owner cancel is ignored
        @(negedge clk);
        c = cyc;
        req = 2'b01;
        req_dur = {8'd0, 8'd2};
        sb_push(2'b01, c + 1 + 2 * DIV);
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            req = 2'b00;
            cancel = (j <= 8) ? 2'b10 : 2'b00;
            if (j == 4) chk("nocancel_grant", int'(grant), 1);
            if (j == 8) chk("nocancel_remain", int'(remain), 1);
        end
        cancel = 2'b00;

        // Reset mid-RUN with remain=4, then req1 alone
        wait_idle();
        @(negedge clk);
        req = 2'b01;
        req_dur = {8'd0, 8'd5};
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            req = 2'b00;
        end
        chk("midrst_remain_before", int'(remain), 4);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst_n = 1'b0;
        @(negedge clk);
        c = cyc;
        req = 2'b10;
        req_dur = {8'd1, 8'd0};
        sb_push(2'b10, c + 1 + DIV);
        @(negedge clk);
        chk("midrst_req1_grant", int'(grant), 2);
        req = 2'b00;
        repeat (6) @(negedge clk);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
